// File: rtl/mn_soc_host_de10_nano_soc_button_debounce.sv
// rtl/mn_soc_host_de10_nano_soc_button_debounce.sv - KEY button synchroniser, debouncer and glitch counter
module mn_soc_host_de10_nano_soc_button_debounce #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               CNT_WIDTH       = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button_in,
    output logic [WIDTH-1:0] button_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    input  logic             glitch_clr,
    output logic [15:0]      glitch_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0]     sync0;
    logic [WIDTH-1:0]     sync1;
    logic [WIDTH-1:0]     reject;
    state_t               state [WIDTH];
    logic [CNT_WIDTH-1:0] cnt   [WIDTH];
    logic [31:0]          glitch_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= RESET_VALUE;
            sync1 <= RESET_VALUE;
        end else begin
            sync0 <= button_in;
            sync1 <= sync0;
        end
    end

    // A channel rejects when it was qualifying a new level and the synchronised input fell back.
    always_comb begin
        reject = '0;
        for (int i = 0; i < WIDTH; i++) begin
            reject[i] = (state[i] == PENDING) && (sync1[i] == button_out[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            button_out    <= RESET_VALUE;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                case (state[i])
                    STABLE: begin
                        if (sync1[i] != button_out[i]) begin
                            state[i] <= PENDING;
                            cnt[i]   <= CNT_WIDTH'(1);
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    PENDING: begin
                        if (sync1[i] == button_out[i]) begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            button_out[i]    <= sync1[i];
                            press_pulse[i]   <= ~sync1[i];
                            release_pulse[i] <= sync1[i];
                            state[i]         <= STABLE;
                            cnt[i]           <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state[i] <= STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Wide sum so that several simultaneous rejects near the top still saturate instead of wrapping.
    always_comb begin
        glitch_sum = {16'b0, glitch_count};
        for (int i = 0; i < WIDTH; i++) begin
            glitch_sum = glitch_sum + 32'(reject[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_count <= '0;
        end else if (glitch_clr) begin
            glitch_count <= '0;
        end else if (glitch_sum > 32'h0000_FFFF) begin
            glitch_count <= 16'hFFFF;
        end else begin
            glitch_count <= glitch_sum[15:0];
        end
    end

endmodule

// File: doc/mn_soc_host_de10_nano_soc_button_debounce.md
# mn_soc_host_de10_nano_soc_button_debounce

Debounces and synchronises the raw DE10-Nano KEY push-button inputs before they reach the button PIO's `in_port`. Each channel has a 2-FF synchroniser, a stability counter and a per-channel state machine. Channel outputs change only after the input has held a new level for a programmable number of clocks. The block also emits one-cycle press/release strobes and keeps a saturating glitch counter for board bring-up diagnostics.

## Interface
- `WIDTH`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable clocks required to accept a new level (20 ms at 50 MHz); legal range 2..2^`CNT_WIDTH`.
- `CNT_WIDTH`, 20: width of each channel's stability counter.
- `RESET_VALUE`, {WIDTH{1'b1}}: reset level of synchronisers and outputs (buttons are active-low, so 1 = released).

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `reset_n` in 1: reset, asynchronous and active-low.
- `button_in` in WIDTH: raw asynchronous pad inputs.
- `button_out` out WIDTH: debounced level; drives PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle strobe when `button_out[i]` goes 1→0.
- `release_pulse` out WIDTH: one-cycle strobe when `button_out[i]` goes 0→1.
- `glitch_clr` in 1: synchronous clear of `glitch_count`.
- `glitch_count` out 16: saturating count of rejected transitions, summed over all channels.

## Operation
- Synchroniser per channel: `sync0 <= button_in`, then `sync1 <= sync0`. Both reset to `RESET_VALUE`. Only `sync1` is used downstream.
- Each channel has a 2-state FSM:
  - **STABLE**: `cnt` = 0.
    - If `sync1 != button_out`, go to PENDING and set `cnt <= 1`.
  - **PENDING**:
    - If `sync1 == button_out`, the transition is rejected: go to STABLE, `cnt <= 0`, and count one glitch.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, accept the new level: `button_out[i] <= sync1`, go to STABLE, `cnt <= 0`, and assert the matching pulse.
    - Else `cnt <= cnt+1`.
- Net rule: `button_out[i]` takes the new value at the edge that completes `DEBOUNCE_CYCLES` consecutive edges with `sync1 != button_out`. Any equal sample restarts the count from zero.
- Pulses are registered and high for exactly the one cycle following the `button_out` change. `press_pulse` and `release_pulse` are never high together on a channel.
- Glitch counter:
  - Per-cycle increment equals the number of channels rejecting in that cycle (0..WIDTH).
  - The sum saturates at 0xFFFF and never wraps.
  - `glitch_clr` has priority: the counter goes to 0 and increments in that same cycle are discarded.
- Channels are fully independent. Simultaneous accepts on several channels produce simultaneous pulses.

## Timing
- Reset values:
  - `button_out` = `RESET_VALUE`.
  - `press_pulse`, `release_pulse` = 0.
  - `glitch_count` = 0.
  - All FSMs in STABLE, all `cnt` = 0.
- Latency from edge E0 (where `sync0` first captures a new stable level):
  - `button_out` changes at edge E0+1+`DEBOUNCE_CYCLES`.
  - The pulse is visible in the cycle after that edge.
- A glitch is rejected at the first edge where `sync1` is back to `button_out`. `glitch_count` updates at that same edge.
- If `reset_n` is asserted mid-PENDING, the FSM, counter and output return to reset values immediately. No pulse is produced. After release the input is re-qualified from scratch; when `button_in` differs from `RESET_VALUE`, the full `DEBOUNCE_CYCLES` are required.
- Outputs are glitch-free registers. The PIO sees clean single transitions, so each press sets its edge capture exactly once.

## Test plan
- Reset: `reset_n` low with `button_in`=2'b00 → `button_out`=2'b11, pulses 0, `glitch_count`=0. After release, `button_out[1:0]` goes to 2'b00 exactly DEBOUNCE_CYCLES+2 edges later with `press_pulse`=2'b11 for one cycle.
- Clean press (`DEBOUNCE_CYCLES`=4): `button_in[0]` 1→0 held → `button_out[0]`=0 at edge E0+5, `press_pulse[0]` high one cycle. Release the same way → `release_pulse[0]` high one cycle.
- Bounce: `button_in[1]` low for 3 cycles then high, repeated 5 times → `button_out[1]` stays 1, `glitch_count`=5, no pulses.
- Simultaneous glitches: both channels glitch in the same cycle with `glitch_count`=0xFFFE → 0xFFFF, saturated. Assert `glitch_clr` during another double glitch → 0.
- Reset mid-PENDING: assert `reset_n` after 2 of 4 stable cycles → output stays at 1 with no pulse. After release, a held-low input is accepted 4+2 edges later.
- Long hold: press held 1000 cycles → exactly one `press_pulse`, counters idle, `glitch_count` unchanged.
